// File: rtl/mul_arbiter_pkg.sv
// Shared multiply-unit definitions: funct3 codes, the in-flight slot record,
// and the product-half selector.
package mdu_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  // Wide enough for any practical requester count; the top truncates on output.
  localparam int ID_MAXW = 8;

  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic [2:0]         funct3;
  } mslot_t;

  function automatic logic is_high_half(input logic [2:0] f3);
    case (f3)
      MUL_F3:                       return 1'b0;
      MULH_F3, MULHSU_F3, MULHU_F3: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_arbiter_rrarb.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i.
module rrarb #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (en_i && !found && elig_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one two-stage multiplier between NREQ requesters; tracks the op held
// in the multiplier's pipeline register and returns the selected product half.
module mul_arbiter
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           ReqValid,
  output logic [NREQ-1:0]           ReqReady,
  input  logic [NREQ*XLEN-1:0]      ReqSrcA,
  input  logic [NREQ*XLEN-1:0]      ReqSrcB,
  input  logic [NREQ*3-1:0]         ReqFunct3,
  input  logic [NREQ-1:0]           ReqFlush,
  output logic [XLEN-1:0]           MulSrcA,
  output logic [XLEN-1:0]           MulSrcB,
  output logic [2:0]                MulFunct3,
  output logic                      MulStall,
  output logic                      MulFlush,
  input  logic [2*XLEN-1:0]         MulProd,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic [$clog2(NREQ)-1:0]   RspId,
  output logic [XLEN-1:0]           RspResult
);

  localparam int IDW = $clog2(NREQ);

  mslot_t          slot_q, slot_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] elig, grant, id_match;
  logic [IDW-1:0]  win;
  logic            flush_hit, can_issue, accept, rsp_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_idm
      assign id_match[gi] = (slot_q.id == ID_MAXW'(gi));
    end
  endgenerate

  assign flush_hit = slot_q.valid & |(id_match & ReqFlush);
  assign MulFlush  = ~reset | flush_hit;
  assign RspValid  = reset & slot_q.valid & ~flush_hit;
  assign MulStall  = reset & slot_q.valid & ~RspReady;
  assign rsp_fire  = RspValid & RspReady;
  // Multiplier clear beats load, so nothing issues while MulFlush is up.
  assign can_issue = ~MulFlush & (~slot_q.valid | rsp_fire);
  assign elig      = ReqValid & ~ReqFlush;

  rrarb #(.NREQ(NREQ)) u_rrarb (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .en_i    (can_issue),
    .grant_o (grant),
    .idx_o   (win)
  );

  assign accept    = |grant;
  assign ReqReady  = grant;
  assign MulSrcA   = accept ? ReqSrcA[win*XLEN +: XLEN] : '0;
  assign MulSrcB   = accept ? ReqSrcB[win*XLEN +: XLEN] : '0;
  assign MulFunct3 = accept ? ReqFunct3[win*3 +: 3] : '0;

  assign RspId     = slot_q.id[IDW-1:0];
  assign RspResult = is_high_half(slot_q.funct3) ? MulProd[2*XLEN-1:XLEN]
                                                 : MulProd[XLEN-1:0];

  always_comb begin
    slot_d = slot_q;
    ptr_d  = ptr_q;
    if (accept) begin
      slot_d.valid  = 1'b1;
      slot_d.id     = ID_MAXW'(win);
      slot_d.funct3 = MulFunct3;
      ptr_d         = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (rsp_fire | flush_hit) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q <= '0;
      ptr_q  <= '0;
    end else begin
      slot_q <= slot_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter (XLEN=32, NREQ=2) with a behavioural multiplier,
// a cycle-level reference model and directed literal checks.
module tb_mul_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      ReqValid, ReqReady, ReqFlush;
  logic [NREQ*XLEN-1:0] ReqSrcA, ReqSrcB;
  logic [NREQ*3-1:0]    ReqFunct3;
  logic [XLEN-1:0]      MulSrcA, MulSrcB, RspResult;
  logic [2:0]           MulFunct3;
  logic                 MulStall, MulFlush, RspValid, RspReady;
  logic [2*XLEN-1:0]    MulProd;
  logic [0:0]           RspId;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqSrcA(ReqSrcA), .ReqSrcB(ReqSrcB), .ReqFunct3(ReqFunct3), .ReqFlush(ReqFlush),
    .MulSrcA(MulSrcA), .MulSrcB(MulSrcB), .MulFunct3(MulFunct3),
    .MulStall(MulStall), .MulFlush(MulFlush), .MulProd(MulProd),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId), .RspResult(RspResult)
  );

  function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'b010:  return sa * longint'(ub);
      3'b011:  return ua * ub;
      default: return sa * sb;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3);
    logic [63:0] p;
    p = full_prod(a, b, f3);
    return (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) ? p[63:32] : p[31:0];
  endfunction

  // Environment: two-stage multiplier whose second stage is the product register.
  always @(posedge clk) begin
    if (MulFlush)       MulProd <= '0;
    else if (!MulStall) MulProd <= full_prod(MulSrcA, MulSrcB, MulFunct3);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending op (owner, precomputed answer) and a pointer.
  bit          m_pv = 1'b0;
  int          m_pid = 0;
  logic [31:0] m_res = '0;
  int          m_ptr = 0;

  always @(negedge clk) begin : model
    bit hit, ev, can;
    int win, j;
    logic [1:0]  er;
    logic [31:0] ea, eb;
    logic [2:0]  ef3;
    hit = 1'b0; ev = 1'b0; can = 1'b0; win = -1; j = 0;
    er = '0; ea = '0; eb = '0; ef3 = '0;
    if (reset) begin
      hit = m_pv && ReqFlush[1'(m_pid)];
      ev  = m_pv && !hit;
      can = !hit && (!m_pv || (ev && RspReady));
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (can && win < 0 && ReqValid[1'(j)] && !ReqFlush[1'(j)]) win = j;
      end
      if (win >= 0) begin
        er[1'(win)] = 1'b1;
        ea  = ReqSrcA[win*XLEN +: XLEN];
        eb  = ReqSrcB[win*XLEN +: XLEN];
        ef3 = ReqFunct3[win*3 +: 3];
      end
    end
    check("mdl_ready",  64'(ReqReady),  64'(er));
    check("mdl_rspv",   64'(RspValid),  64'(ev));
    check("mdl_flush",  64'(MulFlush),  64'(!reset || hit));
    check("mdl_stall",  64'(MulStall),  64'(reset && m_pv && !RspReady));
    check("mdl_srca",   64'(MulSrcA),   64'(ea));
    check("mdl_srcb",   64'(MulSrcB),   64'(eb));
    check("mdl_f3",     64'(MulFunct3), 64'(ef3));
    if (ev) begin
      check("mdl_rspid",  64'(RspId),     64'(m_pid));
      check("mdl_result", 64'(RspResult), 64'(m_res));
    end
    // state as it will be after the coming rising edge
    if (!reset) begin
      m_pv = 1'b0; m_ptr = 0;
    end else if (win >= 0) begin
      m_pv = 1'b1; m_pid = win; m_res = exp_result(ea, eb, ef3);
      m_ptr = (win + 1) % NREQ;
    end else if ((ev && RspReady) || hit) begin
      m_pv = 1'b0;
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3);
    ReqSrcA[i*XLEN +: XLEN] = a;
    ReqSrcB[i*XLEN +: XLEN] = b;
    ReqFunct3[i*3 +: 3]     = f3;
  endtask

  task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [31:0] exp);
    set_req(0, a, b, f3); ReqValid = 2'b01;
    neg(); check({name, "_ready"}, 64'(ReqReady), 64'h1);
    nxt(); ReqValid = 2'b00;
    neg(); check({name, "_rspv"}, 64'(RspValid), 64'h1);
    check({name, "_result"}, 64'(RspResult), 64'(exp));
    $display("[TB] %s result %h", name, RspResult);
    nxt();
  endtask

  initial begin
    reset = 1'b0; ReqValid = '0; ReqFlush = '0; RspReady = 1'b1;
    ReqSrcA = '0; ReqSrcB = '0; ReqFunct3 = '0;
    neg();
    check("rst_ready", 64'(ReqReady), 64'h0);
    check("rst_rspv",  64'(RspValid), 64'h0);
    check("rst_flush", 64'(MulFlush), 64'h1);
    check("rst_stall", 64'(MulStall), 64'h0);
    nxt(); reset = 1'b1;

    single_op("single", 32'd7, 32'd6, 3'b000, 32'd42);

    // pointer now at 1; a reset pulse must bring it back to 0
    reset = 1'b0; neg(); nxt(); reset = 1'b1;
    set_req(0, 32'd3, 32'd5, 3'b000); set_req(1, 32'd4, 32'd9, 3'b000);
    ReqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      neg();
      check("cont_grant", 64'(ReqReady), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) begin
        check("cont_id",     64'(RspId),     64'((k - 1) % 2));
        check("cont_result", 64'(RspResult), ((k - 1) % 2 == 0) ? 64'd15 : 64'd36);
      end
      $display("[TB] contention cycle %0d ReqReady=%b RspId=%0d", k, ReqReady, RspId);
      nxt();
    end
    ReqValid = 2'b00;
    neg(); check("cont_last_id", 64'(RspId), 64'h1); check("cont_last_res", 64'(RspResult), 64'd36);
    nxt();

    single_op("mulh",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'h00000000);
    single_op("mulhu",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE);
    single_op("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF);
    single_op("mul",    32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h00000001);

    // backpressure
    set_req(0, 32'd7, 32'd6, 3'b000); ReqValid = 2'b01;
    neg(); check("bp_ready0", 64'(ReqReady), 64'h1);
    nxt(); ReqValid = 2'b10; set_req(1, 32'd2, 32'd3, 3'b000); RspReady = 1'b0;
    repeat (3) begin
      neg();
      check("bp_rspv",   64'(RspValid),  64'h1);
      check("bp_result", 64'(RspResult), 64'd42);
      check("bp_stall",  64'(MulStall),  64'h1);
      check("bp_ready",  64'(ReqReady),  64'h0);
      $display("[TB] backpressure hold result %0d", RspResult);
      nxt();
    end
    RspReady = 1'b1;
    neg(); check("bp_hs_rspv", 64'(RspValid), 64'h1); check("bp_hs_ready", 64'(ReqReady), 64'h2);
    nxt(); ReqValid = 2'b00;
    neg(); check("bp_r1_id", 64'(RspId), 64'h1); check("bp_r1_res", 64'(RspResult), 64'd6);
    nxt();

    // owner flush
    set_req(1, 32'd5, 32'd5, 3'b000); ReqValid = 2'b10;
    neg(); check("fl_ready1", 64'(ReqReady), 64'h2);
    nxt(); ReqValid = 2'b01; set_req(0, 32'd7, 32'd8, 3'b000); ReqFlush = 2'b10;
    neg();
    check("fl_rspv",  64'(RspValid), 64'h0);
    check("fl_flush", 64'(MulFlush), 64'h1);
    check("fl_ready", 64'(ReqReady), 64'h0);
    $display("[TB] flush cycle RspValid=%b MulFlush=%b", RspValid, MulFlush);
    nxt(); ReqFlush = 2'b00;
    neg(); check("fl_ready0", 64'(ReqReady), 64'h1);
    nxt(); ReqValid = 2'b00;
    neg(); check("fl_r0_id", 64'(RspId), 64'h0); check("fl_r0_res", 64'(RspResult), 64'd56);
    nxt();

    // flush aimed at a non-owner
    set_req(0, 32'd3, 32'd3, 3'b000); ReqValid = 2'b01;
    neg(); check("nof_ready", 64'(ReqReady), 64'h1);
    nxt(); ReqValid = 2'b00; ReqFlush = 2'b10;
    neg(); check("nof_rspv", 64'(RspValid), 64'h1); check("nof_res", 64'(RspResult), 64'd9);
    check("nof_flush", 64'(MulFlush), 64'h0);
    nxt(); ReqFlush = 2'b00;

    // reset mid-operation
    set_req(0, 32'd9, 32'd9, 3'b000); ReqValid = 2'b01;
    neg(); check("rmo_ready", 64'(ReqReady), 64'h1);
    nxt(); ReqValid = 2'b00; reset = 1'b0; RspReady = 1'b0;
    neg(); check("rmo_rspv", 64'(RspValid), 64'h0); check("rmo_flush", 64'(MulFlush), 64'h1);
    check("rmo_ready_rst", 64'(ReqReady), 64'h0);
    nxt(); reset = 1'b1; RspReady = 1'b1; ReqValid = 2'b10; set_req(1, 32'd6, 32'd7, 3'b000);
    neg(); check("rmo_dropped", 64'(RspValid), 64'h0); check("rmo_ready1", 64'(ReqReady), 64'h2);
    nxt(); ReqValid = 2'b00;
    neg(); check("rmo_r1_id", 64'(RspId), 64'h1); check("rmo_r1_res", 64'(RspResult), 64'd42);
    $display("[TB] post-reset req1 result %0d", RspResult);
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
